// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier family.
// Holds the FSM state encoding, the recoded-digit flag struct with its
// constants, and the digit-count helper.
package booth_pkg;

  // Iterative multiplier control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Recoded digit as magnitude-select flags plus sign
  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_dig_t;

  localparam booth_dig_t DIG_ZERO = '{neg: 1'b0, two: 1'b0, one: 1'b0};
  localparam booth_dig_t DIG_POS1 = '{neg: 1'b0, two: 1'b0, one: 1'b1};
  localparam booth_dig_t DIG_POS2 = '{neg: 1'b0, two: 1'b1, one: 1'b0};
  localparam booth_dig_t DIG_NEG1 = '{neg: 1'b1, two: 1'b0, one: 1'b1};
  localparam booth_dig_t DIG_NEG2 = '{neg: 1'b1, two: 1'b1, one: 1'b0};

  // Digits needed for a WIDTH-bit operand extended by two bits
  function automatic int unsigned booth_digits(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth recoder: one overlapping multiplier triplet to digit flags.
// Ports:
//   i_triplet  {y[2i+1], y[2i], y[2i-1]}
//   o_digit_c  combinational {neg, two, one}; zero digits never set neg
module booth_r4_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0] i_triplet,
  output booth_dig_t o_digit_c
);

  always_comb begin
    o_digit_c = DIG_ZERO;
    case (i_triplet)
      3'b001, 3'b010: o_digit_c = DIG_POS1;
      3'b011:         o_digit_c = DIG_POS2;
      3'b100:         o_digit_c = DIG_NEG2;
      3'b101, 3'b110: o_digit_c = DIG_NEG1;
      default:        o_digit_c = DIG_ZERO;
    endcase
  end

endmodule

// File: rtl/radix4_booth_serial_mult.sv
// Iterative radix-4 Booth multiplier, one recoded digit per clock.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          request, accepted in IDLE or DONE
//   signed_mode    1 = two's complement operands, 0 = unsigned
//   x, y           multiplicand / multiplier, captured on accept
//   busy           high while digits are being retired
//   done           one-cycle pulse when product updates
//   product        2*WIDTH-bit result, held until the next completion
module radix4_booth_serial_mult
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned N     = booth_digits(WIDTH);
  localparam int unsigned CNT_W = $clog2(N);
  localparam int unsigned EXT_W = WIDTH + 2;
  localparam int unsigned PP_W  = WIDTH + 4;
  localparam int unsigned ACC_W = 2 * WIDTH + 4;
  localparam int unsigned YSH_W = EXT_W + 1;

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("radix4_booth_serial_mult: WIDTH must be even and >= 4");
  end

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_last;
  logic [EXT_W-1:0]    r_x;
  logic [YSH_W-1:0]    r_y;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [2*WIDTH-1:0]  r_product;

  logic [EXT_W-1:0]    w_x_ext;
  logic [EXT_W-1:0]    w_y_ext;
  booth_dig_t          w_dig;
  logic [PP_W-1:0]     w_x_pp;
  logic [PP_W-1:0]     w_mag;
  logic [PP_W-1:0]     w_op;
  logic [PP_W-1:0]     w_hi;
  logic [ACC_W-1:0]    w_sum;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state, accept and last-digit decode
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(N - 1)) begin
          w_last = 1'b1;
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Two-bit operand extension; the extra top bits make unsigned values positive
  assign w_x_ext = signed_mode ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  assign w_y_ext = signed_mode ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};

  // Multiplier is kept shifted so the current triplet is always r_y[2:0]
  booth_r4_digit_enc u_digit_enc (
    .i_triplet (r_y[2:0]),
    .o_digit_c (w_dig)
  );

  // Partial product select; negation completes via the carry-in below
  assign w_x_pp = {{2{r_x[EXT_W-1]}}, r_x};
  assign w_mag  = w_dig.one ? w_x_pp : (w_dig.two ? (w_x_pp << 1) : '0);
  assign w_op   = w_dig.neg ? ~w_mag : w_mag;
  assign w_hi   = r_acc[ACC_W-1:WIDTH] + w_op + PP_W'(w_dig.neg);
  assign w_sum  = {w_hi, r_acc[WIDTH-1:0]};

  // Datapath and registered outputs.
  // The final digit's unshifted sum already sits at the product weight,
  // so the product is taken from w_sum rather than the shifted accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      if (w_accept) begin
        r_x   <= w_x_ext;
        r_y   <= {w_y_ext, 1'b0};
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_acc <= {{2{w_sum[ACC_W-1]}}, w_sum[ACC_W-1:2]};
        r_y   <= r_y >> 2;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last) r_product <= w_sum[2*WIDTH-1:0];
      r_busy <= (w_next == ST_RUN);
      r_done <= (w_next == ST_DONE);
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_radix4_booth_serial_mult.sv
// Directed and randomised checks for radix4_booth_serial_mult (WIDTH=8).
module tb_radix4_booth_serial_mult;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_pass;
  int n_fail;
  int n_total;
  int n_viol;
  logic prev_done;

  radix4_booth_serial_mult #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .x           (x),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake invariants observed mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (busy && done) n_viol++;
      if (done && prev_done) n_viol++;
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string tag);
    int cyc;
    signed_mode = sm;
    x           = a;
    y           = b;
    start       = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'd6);
    check(tag, 32'(product), 32'(exp));
    tick();
  endtask

  initial begin
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;

    n_pass = 0; n_fail = 0; n_total = 0; n_viol = 0; prev_done = 1'b0;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; x = '0; y = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);

    // -7 * 13 with exact cycle-by-cycle busy/done profile
    signed_mode = 1'b1; x = 8'hF9; y = 8'h0D; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_done_low", 32'(done), 32'd0);
      tick();
    end
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_product", 32'(product), 32'h0000FFA5);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);

    run_op(1'b0, 8'hFF, 8'hFF, 16'hFE01, "t2_unsigned_ff");
    run_op(1'b1, 8'hFF, 8'hFF, 16'h0001, "t2_signed_ff");

    run_op(1'b1, 8'h00, 8'h55, 16'h0000, "t3_zero");
    run_op(1'b1, 8'h80, 8'h80, 16'h4000, "t3_min_min");
    run_op(1'b1, 8'h80, 8'h7F, 16'hC080, "t3_min_max");
    run_op(1'b0, 8'h80, 8'h03, 16'h0180, "t3_unsigned_80x3");

    // start held through RUN, accepted again in DONE
    signed_mode = 1'b0; x = 8'h0B; y = 8'h0D; start = 1'b1;
    tick();
    x = 8'h02; y = 8'h03;
    for (int i = 0; i < 5; i++) begin
      check("t4_run1_busy", 32'(busy), 32'd1);
      check("t4_run1_hold", 32'(product), 32'h00000180);
      tick();
    end
    check("t4_done1", 32'(done), 32'd1);
    check("t4_product1", 32'(product), 32'h0000008F);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_run2_busy", 32'(busy), 32'd1);
      check("t4_run2_done", 32'(done), 32'd0);
      check("t4_run2_hold", 32'(product), 32'h0000008F);
      tick();
    end
    check("t4_done2", 32'(done), 32'd1);
    check("t4_product2", 32'(product), 32'h00000006);
    tick();

    // Reset in the third RUN cycle discards the operation
    signed_mode = 1'b0; x = 8'h0B; y = 8'h0D; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_product", 32'(product), 32'd0);
    tick();
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_done", 32'(done), 32'd0);
    run_op(1'b0, 8'h12, 8'h34, 16'h03A8, "t5_after_rst");

    // Random operations against a reference product
    for (int i = 0; i < 10000; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      if (sm) exp = 16'($signed(a) * $signed(b));
      else    exp = 16'(a * b);
      run_op(sm, a, b, exp, "t6_rand");
    end
    check("t6_handshake_viol", 32'(n_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
